// File: rtl/usb_pkg.sv
// Shared USB packet definitions: packet classes, sync pattern, CRC
// polynomials/residues, payload lengths and PID classification.
package usb_pkg;

  typedef enum logic [1:0] {
    HANDSHAKE,
    TOKEN,
    DATA
  } pkt_type_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_PAYLOAD,
    S_CRC,
    S_DONE
  } enc_state_t;

  localparam logic [7:0]  SYNC          = 8'h01;
  localparam logic [4:0]  CRC5_POLY     = 5'b00101;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;
  localparam int          TOKEN_LEN     = 11;
  localparam int          DATA_LEN      = 64;

  function automatic pkt_type_t pid_class(
    input logic [3:0] p
  );
    pkt_type_t t;
    t = HANDSHAKE;
    if (p[3:1] == 3'b100) t = TOKEN;
    else if (p == 4'b1100) t = DATA;
    return t;
  endfunction

endpackage

// File: rtl/crc_gen.sv
// Serial LFSR CRC generator, MSB-first, preset to all ones.
// Ports: clk, rst_b, preset (load ones), en (shift bitIn), crc (register).
module crc_gen #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = '0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             preset,
  input  logic             en,
  input  logic             bitIn,
  output logic [WIDTH-1:0] crc
);

  logic fb;

  assign fb = crc[WIDTH-1] ^ bitIn;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      crc <= '1;
    end else if (preset) begin
      crc <= '1;
    end else if (en) begin
      crc <= {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/crc_encoder.sv
// Serial USB packet transmitter: sync, PID, payload, complemented CRC.
// Ports: clk, rst_b, pid/addr/endp/data + pktInAvail/readyIn (packet in),
// bitOut/bitOutAvail/readyOut (serial out), pktSent (done pulse).
module crc_encoder
  import usb_pkg::*;
#(
  parameter int DATA_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [3:0]           pid,
  input  logic [6:0]           addr,
  input  logic [3:0]           endp,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 pktInAvail,
  output logic                 readyIn,
  output logic                 bitOut,
  output logic                 bitOutAvail,
  input  logic                 readyOut,
  output logic                 pktSent
);

  enc_state_t state, state_n;
  pkt_type_t kind_q;
  logic [6:0] cnt;
  logic [3:0] pid_q;
  logic [DATA_BITS-1:0] pay_q;
  logic [4:0] crc5;
  logic [15:0] crc16;
  logic [15:0] crc_sel;
  logic [7:0] pid_byte;
  logic [2:0] bidx;
  logic [3:0] cidx;
  logic xfer, accept, seg_last;

  assign xfer   = bitOutAvail && readyOut;
  assign accept = pktInAvail && readyIn;

  assign pid_byte = {pid_q, ~pid_q};
  assign bidx     = 3'd7 - cnt[2:0];
  assign cidx     = 4'd15 - cnt[3:0];
  // CRC5 left-aligned so both widths read out from bit 15 down.
  assign crc_sel  = (kind_q == TOKEN) ? {crc5, 11'b0} : crc16;

  crc_gen #(.WIDTH(5), .POLY(CRC5_POLY)) u_crc5 (
    .clk    (clk),
    .rst_b  (rst_b),
    .preset (accept),
    .en     (xfer && state == S_PAYLOAD),
    .bitIn  (pay_q[DATA_BITS-1]),
    .crc    (crc5)
  );

  crc_gen #(.WIDTH(16), .POLY(CRC16_POLY)) u_crc16 (
    .clk    (clk),
    .rst_b  (rst_b),
    .preset (accept),
    .en     (xfer && state == S_PAYLOAD),
    .bitIn  (pay_q[DATA_BITS-1]),
    .crc    (crc16)
  );

  always_comb begin
    seg_last = 1'b0;
    unique case (state)
      S_SYNC, S_PID: seg_last = (cnt == 7'd7);
      S_PAYLOAD: seg_last = (kind_q == TOKEN)
                          ? (cnt == 7'(TOKEN_LEN - 1))
                          : (cnt == 7'(DATA_LEN - 1));
      S_CRC: seg_last = (kind_q == TOKEN)
                      ? (cnt == 7'd4) : (cnt == 7'd15);
      default: seg_last = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (accept) state_n = S_SYNC;
      S_SYNC: if (xfer && seg_last) state_n = S_PID;
      S_PID: begin
        if (xfer && seg_last) begin
          state_n = (kind_q == HANDSHAKE) ? S_DONE : S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (xfer && seg_last) state_n = S_CRC;
      S_CRC: if (xfer && seg_last) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) cnt <= '0;
      else if (xfer) cnt <= cnt + 7'd1;
    end
  end

  // Token payload is left-aligned so both kinds shift out of the MSB.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pid_q  <= '0;
      kind_q <= HANDSHAKE;
      pay_q  <= '0;
    end else if (accept) begin
      pid_q  <= pid;
      kind_q <= pid_class(pid);
      pay_q  <= (pid_class(pid) == TOKEN)
              ? {addr, endp, {(DATA_BITS-11){1'b0}}}
              : data;
    end else if (xfer && state == S_PAYLOAD) begin
      pay_q <= {pay_q[DATA_BITS-2:0], 1'b0};
    end
  end

  always_comb begin
    readyIn     = 1'b0;
    bitOutAvail = 1'b0;
    pktSent     = 1'b0;
    bitOut      = 1'b0;
    unique case (state)
      S_IDLE: readyIn = 1'b1;
      S_SYNC: begin
        bitOutAvail = 1'b1;
        bitOut      = SYNC[bidx];
      end
      S_PID: begin
        bitOutAvail = 1'b1;
        bitOut      = pid_byte[bidx];
      end
      S_PAYLOAD: begin
        bitOutAvail = 1'b1;
        bitOut      = pay_q[DATA_BITS-1];
      end
      S_CRC: begin
        bitOutAvail = 1'b1;
        bitOut      = ~crc_sel[cidx];
      end
      S_DONE: pktSent = 1'b1;
      default: ;
    endcase
  end

endmodule
